monitor_report_ctrl: RTL and testbench
======================================

MONITOR_REPORT_CTRL -- requirements
Module: monitor_report_ctrl

Interface
REQ-001 SHALL have parameter RPT_W, default 36, meaning report bits from one automata stage (9 automata x 4 reports).
REQ-002 SHALL have parameter DEPTH, default 4, meaning report FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter CNT_W, default 16, meaning symbol-index stamp width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, meaning a symbol is offered.
REQ-007 SHALL have port in_symbol, input, 8, meaning the offered symbol.
REQ-008 SHALL have port in_ready, output, 1, meaning the controller accepts the symbol this cycle.
REQ-009 SHALL have port flush_req, input, 1, meaning a one-cycle pulse requesting an automata restart.
REQ-010 SHALL have port run, output, 1, meaning the stage consumes top_symbols this cycle.
REQ-011 SHALL have port top_symbols, output, 8, meaning the symbol driven to the stage.
REQ-012 SHALL have port stage_reset, output, 1, meaning the restart of the stage automata.
REQ-013 SHALL have port reports, input, RPT_W, meaning the stage report outputs.
REQ-014 SHALL have port rpt_valid, output, 1, meaning the FIFO head is presented.
REQ-015 SHALL have port rpt_ready, input, 1, meaning the consumer takes the FIFO head.
REQ-016 SHALL have port rpt_data, output, RPT_W, meaning the report vector at the FIFO head.
REQ-017 SHALL have port rpt_stamp, output, CNT_W, meaning the symbol index that caused rpt_data.
REQ-018 SHALL have port sym_count, output, CNT_W, meaning symbols issued since the last reset or flush.

Function
REQ-019 SHALL implement the states RUN, FLUSH1, FLUSH2 and DRAIN.
REQ-020 SHALL make issue = in_valid & in_ready; run SHALL equal issue (combinational), and top_symbols SHALL equal in_symbol.
REQ-021 SHALL assert in_ready only in RUN and only when fifo_count + pend < DEPTH, where pend is the one-cycle in-flight issue flag.
REQ-022 SHALL register pend <= issue and stamp_d <= sym_count on every cycle; on issue, sym_count SHALL increment by 1, wrapping from 2^CNT_W-1 to 0.
REQ-023 SHALL sample reports one cycle after issue (when pend=1); when pend=1 and reports != 0, it SHALL push {reports, stamp_d}; when reports == 0 it SHALL push nothing.
REQ-024 SHALL never push when full; REQ-021 guarantees this, and the bench SHALL assert it.
REQ-025 SHALL pop the FIFO head when rpt_valid & rpt_ready; rpt_valid = (fifo_count != 0); rpt_data/rpt_stamp SHALL be stable while rpt_valid & !rpt_ready.
REQ-026 SHALL allow a simultaneous push and pop in the same cycle, leaving fifo_count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-027 SHALL sample flush_req in RUN and move to DRAIN; issue SHALL be blocked from the same cycle.
REQ-028 SHALL, in DRAIN, wait until pend == 0; the FIFO is NOT cleared, and it SHALL then go to FLUSH1.
REQ-029 SHALL assert stage_reset=1 in FLUSH1 and FLUSH2, and return to RUN after FLUSH2.
REQ-030 SHALL clear sym_count to 0 on the FLUSH2->RUN transition.
REQ-031 SHALL ignore flush_req outside RUN.
REQ-032 SHALL stall when rpt_ready=0 indefinitely: in_ready falls once fifo_count + pend reaches DEPTH, with no loss and no overflow.

Reset
REQ-033 SHALL, on reset assertion (asynchronous), set state=RUN, fifo_count=0, pointers=0, pend=0, sym_count=0, stamp_d=0.
REQ-034 SHALL hold outputs at rpt_valid=0, stage_reset=1 and in_ready=0 while reset=1; run SHALL be 0 during reset.
REQ-035 SHALL discard any in-flight report when reset is asserted mid-operation.
REQ-036 SHALL deassert reset synchronously to clk, and in_ready SHALL be allowed from the first edge after deassertion.

Verification
REQ-037 SHALL cover streaming: 10 symbols with in_valid=1 and rpt_ready=1, with reports=36'h0 except after symbol index 3 (36'h0_0000_0010) -> exactly one entry, rpt_data=36'h10, rpt_stamp=3.
REQ-038 SHALL cover backpressure: rpt_ready=0 and every symbol reporting 36'h1 -> in_ready drops after 4 issues, fifo_count=4; then rpt_ready=1 -> stamps 0,1,2,3 in order, then streaming resumes.
REQ-039 SHALL cover flush: flush_req after 5 issues with 2 reports queued -> stage_reset high for exactly 2 cycles, queued entries are still delivered with stamps intact, and the next issued symbol gets stamp 0.
REQ-040 SHALL cover wrap: sym_count preloaded by issuing 65535 symbols, then 2 more reporting -> stamps 65535 and 0.
REQ-041 SHALL cover simultaneous push and pop with the FIFO at 3 entries -> count stays 3, with order preserved.
REQ-042 SHALL cover reset mid-stream: reset asserted with pend=1 and 2 entries queued -> rpt_valid=0 immediately, sym_count=0, and no stale entry after release.

Source files
------------

// File: rtl/monitor_report_ctrl.sv
// Feeds symbols to an automata stage, captures non-zero stage reports one cycle
// later into a small stamped FIFO, and sequences drain/restart on a flush request.
module monitor_report_ctrl #(
   parameter int RPT_W = 36,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_symbol,
   output logic             in_ready,
   input  logic             flush_req,
   output logic             run,
   output logic [7:0]       top_symbols,
   output logic             stage_reset,
   input  logic [RPT_W-1:0] reports,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [RPT_W-1:0] rpt_data,
   output logic [CNT_W-1:0] rpt_stamp,
   output logic [CNT_W-1:0] sym_count
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_FLUSH1 = 2'd2;
   localparam logic [1:0] ST_FLUSH2 = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [AW:0]      count_q, count_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             pend_q;
   logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
   logic [CNT_W-1:0] stamp_q;

   logic [RPT_W-1:0] mem_data_q  [DEPTH];
   logic [CNT_W-1:0] mem_stamp_q [DEPTH];

   logic [AW+1:0]    occ_s;
   logic             ready_s, issue_s, push_s, pop_s;

   // The in-flight symbol counts against capacity, so a report can never find the FIFO full.
   assign occ_s   = {1'b0, count_q} + {{(AW+1){1'b0}}, pend_q};
   assign ready_s = !reset && (state_q == ST_RUN) && !flush_req && (occ_s < (AW+2)'(DEPTH));
   assign issue_s = in_valid && ready_s;
   assign push_s  = pend_q && (reports != '0) && (count_q != (AW+1)'(DEPTH));
   assign pop_s   = (count_q != '0) && rpt_ready;

   assign in_ready    = ready_s;
   assign run         = issue_s;
   assign top_symbols = in_symbol;
   assign stage_reset = reset || (state_q == ST_FLUSH1) || (state_q == ST_FLUSH2);
   assign rpt_valid   = (count_q != '0);
   assign rpt_data    = mem_data_q[rd_ptr_q];
   assign rpt_stamp   = mem_stamp_q[rd_ptr_q];
   assign sym_count   = sym_cnt_q;

   // Next-state for the flush sequencer, FIFO bookkeeping and symbol counter.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      sym_cnt_d = sym_cnt_q;

      case (state_q)
         ST_RUN: begin
            if (flush_req) state_d = ST_DRAIN;
            else           state_d = ST_RUN;
         end
         ST_DRAIN: begin
            if (!pend_q) state_d = ST_FLUSH1;
            else         state_d = ST_DRAIN;
         end
         ST_FLUSH1: state_d = ST_FLUSH2;
         ST_FLUSH2: state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else        wr_ptr_d = wr_ptr_q;

      if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1);
      else       rd_ptr_d = rd_ptr_q;

      if (state_q == ST_FLUSH2) sym_cnt_d = '0;
      else if (issue_s)         sym_cnt_d = sym_cnt_q + CNT_W'(1);
      else                      sym_cnt_d = sym_cnt_q;
   end

   // Control state; reset drops any in-flight report along with the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RUN;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pend_q    <= 1'b0;
         sym_cnt_q <= '0;
         stamp_q   <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pend_q    <= issue_s;
         sym_cnt_q <= sym_cnt_d;
         stamp_q   <= sym_cnt_q;
      end
   end

   // FIFO storage; contents are only meaningful below count_q.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_data_q[wr_ptr_q]  <= reports;
         mem_stamp_q[wr_ptr_q] <= stamp_q;
      end
   end

endmodule

// File: tb/tb_monitor_report_ctrl.sv
// Randomized and directed bench for monitor_report_ctrl against a queue-based
// reference model of the report path and flush timing.
module tb_monitor_report_ctrl;

   localparam int RPT_W = 36;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [RPT_W-1:0] d;
      logic [CNT_W-1:0] s;
   } ent_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [7:0]       in_symbol;
   logic             in_ready;
   logic             flush_req;
   logic             run;
   logic [7:0]       top_symbols;
   logic             stage_reset;
   logic [RPT_W-1:0] reports;
   logic             rpt_valid;
   logic             rpt_ready;
   logic [RPT_W-1:0] rpt_data;
   logic [CNT_W-1:0] rpt_stamp;
   logic [CNT_W-1:0] sym_count;

   monitor_report_ctrl #(.RPT_W(RPT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_symbol(in_symbol),
      .in_ready(in_ready), .flush_req(flush_req), .run(run), .top_symbols(top_symbols),
      .stage_reset(stage_reset), .reports(reports), .rpt_valid(rpt_valid),
      .rpt_ready(rpt_ready), .rpt_data(rpt_data), .rpt_stamp(rpt_stamp),
      .sym_count(sym_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: queued reports, symbol index, pending issue, flush countdown
   ent_t             m_q[$];
   logic [CNT_W-1:0] m_cnt;
   logic             m_pend;
   logic [CNT_W-1:0] m_pend_stamp;
   int               m_flush;
   ent_t             got[$];

   logic             exp_ready, exp_valid, exp_sr, exp_run;
   logic [RPT_W-1:0] exp_data;
   logic [CNT_W-1:0] exp_stamp, exp_cnt;
   logic             obs_ready, obs_valid, obs_sr, obs_run;
   logic [RPT_W-1:0] obs_data;
   logic [CNT_W-1:0] obs_stamp, obs_cnt;
   logic [7:0]       obs_top;

   task automatic model_clear();
      m_q.delete();
      m_cnt        = '0;
      m_pend       = 1'b0;
      m_pend_stamp = '0;
      m_flush      = 0;
   endtask

   // One clock cycle: drive, snapshot outputs and expectations, advance the model.
   task automatic cyc(input logic v, input logic [7:0] s, input logic f,
                      input logic rr, input logic [RPT_W-1:0] rep);
      ent_t e;
      in_valid = v; in_symbol = s; flush_req = f; rpt_ready = rr; reports = rep;
      #1;
      exp_ready = (m_flush == 0) && !f && ((m_q.size() + int'(m_pend)) < DEPTH);
      exp_run   = v && exp_ready;
      exp_valid = (m_q.size() != 0);
      exp_data  = exp_valid ? m_q[0].d : '0;
      exp_stamp = exp_valid ? m_q[0].s : '0;
      exp_sr    = (m_flush == 2) || (m_flush == 1);
      exp_cnt   = m_cnt;
      obs_ready = in_ready;  obs_valid = rpt_valid; obs_sr = stage_reset;
      obs_run   = run;       obs_data  = rpt_data;  obs_stamp = rpt_stamp;
      obs_cnt   = sym_count; obs_top   = top_symbols;
      if (obs_valid && rr) begin
         e.d = obs_data; e.s = obs_stamp;
         got.push_back(e);
      end
      if (exp_valid && rr) void'(m_q.pop_front());
      if (m_pend && rep != '0) begin
         e.d = rep; e.s = m_pend_stamp;
         m_q.push_back(e);
      end
      m_pend       = exp_run;
      m_pend_stamp = m_cnt;
      if (exp_run) m_cnt = m_cnt + 16'd1;
      if (m_flush != 0) begin
         if (m_flush == 1) m_cnt = '0;
         m_flush--;
      end else if (f) begin
         m_flush = 3;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; in_valid = 1'b0; flush_req = 1'b0; rpt_ready = 1'b0;
      reports = '0; in_symbol = 8'h00;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
      got.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; flush_req = 1'b0; rpt_ready = 1'b1;
      reports = 36'h1; in_symbol = 8'h55;
      #2;
      n_tests++; if (run !== 1'b0) begin n_fail++; $display("FAIL rst_run: got %b want 0", run); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", in_ready); end
      n_tests++; if (stage_reset !== 1'b1) begin n_fail++; $display("FAIL rst_sr: got %b want 1", stage_reset); end
      n_tests++; if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rpt_valid); end
      n_tests++; if (sym_count !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", sym_count); end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
      got.delete();
      cyc(1'b1, 8'h55, 1'b0, 1'b1, 36'h0);
      n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", obs_ready); end
      n_tests++; if (sym_count !== 16'd1) begin n_fail++; $display("FAIL rst_release_cnt: got %0d want 1", sym_count); end
   endtask

   task automatic test_stream();
      int issued = 0;
      apply_reset();
      for (int k = 0; k < 16; k++) begin
         cyc(issued < 10, 8'($urandom), 1'b0, 1'b1,
             (m_pend && m_pend_stamp == 16'd3) ? 36'h0_0000_0010 : 36'h0);
         if (obs_run) issued++;
      end
      n_tests++; if (issued != 10) begin n_fail++; $display("FAIL stream_issued: got %0d want 10", issued); end
      n_tests++;
      if (got.size() != 1) begin
         n_fail++; $display("FAIL stream_entries: got %0d want 1", got.size());
      end else if (got[0].d !== 36'h10 || got[0].s !== 16'd3) begin
         n_fail++; $display("FAIL stream_entry: got %h/%0d want 10/3", got[0].d, got[0].s);
      end
   endtask

   task automatic test_backpressure();
      int issued = 0;
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 8'($urandom), 1'b0, 1'b0, m_pend ? 36'h1 : 36'h0);
         if (obs_run) issued++;
      end
      n_tests++; if (issued != 4) begin n_fail++; $display("FAIL bp_issued: got %0d want 4", issued); end
      n_tests++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", obs_ready); end
      for (int k = 0; k < 6; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 36'h0);
      n_tests++;
      if (got.size() != 4) begin
         n_fail++; $display("FAIL bp_drained: got %0d want 4", got.size());
      end else begin
         for (int k = 0; k < 4; k++)
            if (got[k].s !== 16'(k) || got[k].d !== 36'h1) begin
               n_fail++; $display("FAIL bp_order[%0d]: got %h/%0d want 1/%0d", k, got[k].d, got[k].s, k);
            end
      end
      cyc(1'b1, 8'h3C, 1'b0, 1'b1, 36'h0);
      n_tests++; if (obs_run !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b want 1", obs_run); end
   endtask

   task automatic test_flush();
      int issued = 0;
      int sr_cycles = 0;
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 8'($urandom), 1'b0, 1'b0,
             (m_pend && m_pend_stamp == 16'd1) ? 36'hA1 :
             (m_pend && m_pend_stamp == 16'd3) ? 36'hA3 : 36'h0);
         if (obs_run) issued++;
      end
      n_tests++; if (issued != 5) begin n_fail++; $display("FAIL flush_pre_issued: got %0d want 5", issued); end
      cyc(1'b1, 8'h77, 1'b1, 1'b0, 36'h0);
      n_tests++; if (obs_run !== 1'b0) begin n_fail++; $display("FAIL flush_block: got %b want 0", obs_run); end
      for (int k = 0; k < 6; k++) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b0, 36'h0);
         if (obs_sr) sr_cycles++;
      end
      n_tests++; if (sr_cycles != 2) begin n_fail++; $display("FAIL flush_sr_len: got %0d want 2", sr_cycles); end
      n_tests++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL flush_kept: got %b want 1", obs_valid); end
      cyc(1'b1, 8'h42, 1'b0, 1'b0, 36'h0);
      n_tests++; if (obs_run !== 1'b1 || obs_cnt !== 16'd0) begin
         n_fail++; $display("FAIL flush_restart: got run=%b cnt=%0d want 1/0", obs_run, obs_cnt);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 36'hBB);
      for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 36'h0);
      n_tests++;
      if (got.size() != 3) begin
         n_fail++; $display("FAIL flush_entries: got %0d want 3", got.size());
      end else if (got[0].d !== 36'hA1 || got[0].s !== 16'd1 || got[1].d !== 36'hA3 ||
                   got[1].s !== 16'd3 || got[2].d !== 36'hBB || got[2].s !== 16'd0) begin
         n_fail++; $display("FAIL flush_stamps: got %h/%0d %h/%0d %h/%0d want A1/1 A3/3 BB/0",
                            got[0].d, got[0].s, got[1].d, got[1].s, got[2].d, got[2].s);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int k = 0; k < 65535; k++) cyc(1'b1, 8'(k), 1'b0, 1'b1, 36'h0);
      n_tests++; if (sym_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %0d want 65535", sym_count); end
      for (int k = 0; k < 6; k++)
         cyc(k < 2, 8'hEE, 1'b0, 1'b1,
             (m_pend && (m_pend_stamp == 16'hFFFF || m_pend_stamp == 16'h0000)) ?
             (36'h100 + 36'(m_pend_stamp)) : 36'h0);
      n_tests++;
      if (got.size() != 2) begin
         n_fail++; $display("FAIL wrap_entries: got %0d want 2", got.size());
      end else if (got[0].s !== 16'hFFFF || got[1].s !== 16'h0000) begin
         n_fail++; $display("FAIL wrap_stamps: got %0d,%0d want 65535,0", got[0].s, got[1].s);
      end
   endtask

   task automatic test_simul_push_pop();
      apply_reset();
      for (int k = 0; k < 3; k++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, m_pend ? 36'h7 : 36'h0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 36'h7);
      cyc(1'b1, 8'h11, 1'b0, 1'b0, 36'h0);
      n_tests++; if (obs_run !== 1'b1) begin n_fail++; $display("FAIL simul_issue: got %b want 1", obs_run); end
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 36'h9);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 36'h0);
      n_tests++; if (obs_ready !== 1'b1 || obs_valid !== 1'b1 || obs_stamp !== 16'd1) begin
         n_fail++; $display("FAIL simul_count3: got ready=%b valid=%b stamp=%0d want 1/1/1",
                            obs_ready, obs_valid, obs_stamp);
      end
      for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 36'h0);
      n_tests++;
      if (got.size() != 4) begin
         n_fail++; $display("FAIL simul_entries: got %0d want 4", got.size());
      end else begin
         for (int k = 0; k < 4; k++)
            if (got[k].s !== 16'(k) || got[k].d !== ((k == 3) ? 36'h9 : 36'h7)) begin
               n_fail++; $display("FAIL simul_order[%0d]: got %h/%0d", k, got[k].d, got[k].s);
            end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int k = 0; k < 3; k++)
         cyc(1'b1, 8'($urandom), 1'b0, 1'b0, (m_pend && m_pend_stamp < 16'd2) ? 36'h5 : 36'h0);
      n_tests++; if (rpt_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %b want 1", rpt_valid); end
      reset = 1'b1; reports = 36'hFF; in_valid = 1'b1;
      #1;
      n_tests++; if (rpt_valid !== 1'b0 || sym_count !== 16'd0) begin
         n_fail++; $display("FAIL rmid_immediate: got valid=%b cnt=%0d want 0/0", rpt_valid, sym_count);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
      got.delete();
      for (int k = 0; k < 6; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 36'hF);
      n_tests++; if (got.size() != 0 || obs_valid !== 1'b0) begin
         n_fail++; $display("FAIL rmid_stale: got %0d entries valid=%b want 0/0", got.size(), obs_valid);
      end
   endtask

   task automatic test_random();
      logic [63:0] r64;
      logic [RPT_W-1:0] rep;
      logic [7:0] s;
      apply_reset();
      for (int k = 0; k < 1500; k++) begin
         r64 = {$urandom, $urandom};
         rep = ($urandom_range(0, 2) == 0) ? r64[RPT_W-1:0] : '0;
         s   = 8'($urandom);
         cyc($urandom_range(0, 3) != 0, s, $urandom_range(0, 39) == 0,
             $urandom_range(0, 3) != 0, rep);
         n_tests++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", k, obs_ready, exp_ready); end
         n_tests++; if (obs_run !== exp_run) begin n_fail++; $display("FAIL rnd_run@%0d: got %b want %b", k, obs_run, exp_run); end
         n_tests++; if (obs_top !== s) begin n_fail++; $display("FAIL rnd_top@%0d: got %h want %h", k, obs_top, s); end
         n_tests++; if (obs_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", k, obs_valid, exp_valid); end
         n_tests++; if (obs_sr !== exp_sr) begin n_fail++; $display("FAIL rnd_sr@%0d: got %b want %b", k, obs_sr, exp_sr); end
         n_tests++; if (obs_cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", k, obs_cnt, exp_cnt); end
         if (exp_valid) begin
            n_tests++;
            if (obs_data !== exp_data || obs_stamp !== exp_stamp) begin
               n_fail++; $display("FAIL rnd_head@%0d: got %h/%0d want %h/%0d", k, obs_data, obs_stamp, exp_data, exp_stamp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_simul_push_pop();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
